// File: rtl/int_sched_prio.sv
`default_nettype none
// ============================================================================
//  Module   : int_sched_prio
//  Brief    : Priority interrupt scheduler with three nested classes
//             (base < critical < machine-check), edge/level sources,
//             per-class in-service tracking and saved return pc.
//  Revision : 1.0 - initial release
// ============================================================================
module int_sched_prio #(
    parameter int                 NUM_SRC     = 8,
    parameter int                 ADDR_W      = 32,
    parameter logic [NUM_SRC-1:0] EDGE_MASK   = '0,
    parameter logic [NUM_SRC-1:0] CRIT_MASK   = '0,
    parameter logic [NUM_SRC-1:0] MCHECK_MASK = '0,
    parameter logic [NUM_SRC-1:0] EXT_MASK    = '1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_SRC-1:0]         src_req,
    output logic [NUM_SRC-1:0]         src_ack,
    input  logic                       block_external,
    input  logic                       block,
    input  logic [ADDR_W-1:0]          pc,
    output logic                       int_valid,
    output logic [$clog2(NUM_SRC)-1:0] int_id,
    output logic [1:0]                 int_class,
    input  logic                       int_ack,
    input  logic                       rest_base,
    input  logic                       rest_crit,
    input  logic                       rest_mcheck,
    output logic [ADDR_W-1:0]          epc_base,
    output logic [ADDR_W-1:0]          epc_crit,
    output logic [ADDR_W-1:0]          epc_mcheck,
    output logic [2:0]                 active
);

    localparam int ID_W = $clog2(NUM_SRC);

    localparam logic [1:0] CLS_BASE   = 2'd0;
    localparam logic [1:0] CLS_CRIT   = 2'd1;
    localparam logic [1:0] CLS_MCHECK = 2'd2;

    // Machine-check membership overrides critical membership.
    localparam logic [NUM_SRC-1:0] M_MCHK = MCHECK_MASK;
    localparam logic [NUM_SRC-1:0] M_CRIT = CRIT_MASK & ~MCHECK_MASK;
    localparam logic [NUM_SRC-1:0] M_BASE = ~(CRIT_MASK | MCHECK_MASK);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    state_t              state_q,     state_d;
    logic [ID_W-1:0]     int_id_q,    int_id_d;
    logic [1:0]          int_class_q, int_class_d;
    logic [NUM_SRC-1:0]  src_ack_q,   src_ack_d;
    logic [2:0]          active_q,    active_d;
    logic [ADDR_W-1:0]   epc_base_q,  epc_base_d;
    logic [ADDR_W-1:0]   epc_crit_q,  epc_crit_d;
    logic [ADDR_W-1:0]   epc_mchk_q,  epc_mchk_d;
    logic                arm_q,       arm_d;
    logic [NUM_SRC-1:0]  prev_req_q,  prev_req_d;
    logic [NUM_SRC-1:0]  pend_edge_q, pend_edge_d;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic [NUM_SRC-1:0]  pending;
    logic [NUM_SRC-1:0]  eligible;
    logic [2:0]          adm;
    logic [NUM_SRC-1:0]  cand_mchk;
    logic [NUM_SRC-1:0]  cand_crit;
    logic [NUM_SRC-1:0]  cand_base;
    logic [NUM_SRC-1:0]  cand_vec;
    logic                sel_valid;
    logic [ID_W-1:0]     sel_id;
    logic [1:0]          sel_class;
    logic                offer_ok;

    // Edge latching: a new rising edge beats the clear from src_ack.
    always_comb begin
        prev_req_d  = src_req;
        pend_edge_d = (src_req & ~prev_req_q) | (pend_edge_q & ~src_ack_q);
    end

    // Track previous request level and latched edge events.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_req_q  <= '0;
            pend_edge_q <= '0;
        end else begin
            prev_req_q  <= prev_req_d;
            pend_edge_q <= pend_edge_d;
        end
    end

    // Pending/eligible sources; level sources follow the request directly.
    always_comb begin
        pending  = (EDGE_MASK & pend_edge_q) | (~EDGE_MASK & src_req);
        eligible = '0;
        if (!block) begin
            eligible = pending & ~(block_external ? EXT_MASK : '0);
        end
    end

    // Only classes strictly above the highest in-service class may interrupt.
    always_comb begin
        adm = 3'b111;
        if (active_q[2]) begin
            adm = 3'b000;
        end else if (active_q[1]) begin
            adm = 3'b100;
        end else if (active_q[0]) begin
            adm = 3'b110;
        end
    end

    // Winner: highest admissible class, then lowest source index.
    always_comb begin
        cand_mchk = eligible & M_MCHK & {NUM_SRC{adm[2]}};
        cand_crit = eligible & M_CRIT & {NUM_SRC{adm[1]}};
        cand_base = eligible & M_BASE & {NUM_SRC{adm[0]}};
        sel_valid = 1'b0;
        sel_class = CLS_BASE;
        cand_vec  = '0;
        sel_id    = '0;
        if (|cand_mchk) begin
            sel_valid = 1'b1;
            sel_class = CLS_MCHECK;
            cand_vec  = cand_mchk;
        end else if (|cand_crit) begin
            sel_valid = 1'b1;
            sel_class = CLS_CRIT;
            cand_vec  = cand_crit;
        end else if (|cand_base) begin
            sel_valid = 1'b1;
            sel_class = CLS_BASE;
            cand_vec  = cand_base;
        end
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (cand_vec[i]) begin
                sel_id = i[ID_W-1:0];
            end
        end
    end

    // The current offer stays valid while its source is eligible and its
    // class is still admissible (block clears eligibility entirely).
    always_comb begin
        offer_ok = eligible[int_id_q] & adm[int_class_q];
    end

    // Next-state logic for the offer FSM, acknowledges and class tracking.
    always_comb begin
        state_d     = state_q;
        int_id_d    = int_id_q;
        int_class_d = int_class_q;
        src_ack_d   = '0;
        active_d    = active_q & ~{rest_mcheck, rest_crit, rest_base};
        epc_base_d  = epc_base_q;
        epc_crit_d  = epc_crit_q;
        epc_mchk_d  = epc_mchk_q;
        arm_d       = 1'b1;
        case (state_q)
            S_IDLE: begin
                // int_ack is ignored here; only a new winner starts an offer.
                if (arm_q && sel_valid) begin
                    state_d     = S_OFFER;
                    int_id_d    = sel_id;
                    int_class_d = sel_class;
                end
            end
            S_OFFER: begin
                if (int_ack) begin
                    state_d   = S_IDLE;
                    src_ack_d = {{(NUM_SRC-1){1'b0}}, 1'b1} << int_id_q;
                    // Taking an interrupt beats a same-cycle return.
                    active_d[int_class_q] = 1'b1;
                    case (int_class_q)
                        CLS_MCHECK: epc_mchk_d = pc;
                        CLS_CRIT:   epc_crit_d = pc;
                        default:    epc_base_d = pc;
                    endcase
                end else if (!offer_ok) begin
                    state_d = S_IDLE;
                end else if (sel_valid && (sel_class > int_class_q)) begin
                    int_id_d    = sel_id;
                    int_class_d = sel_class;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Offer FSM and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            int_id_q    <= '0;
            int_class_q <= CLS_BASE;
            src_ack_q   <= '0;
            active_q    <= '0;
            epc_base_q  <= '0;
            epc_crit_q  <= '0;
            epc_mchk_q  <= '0;
            arm_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            int_id_q    <= int_id_d;
            int_class_q <= int_class_d;
            src_ack_q   <= src_ack_d;
            active_q    <= active_d;
            epc_base_q  <= epc_base_d;
            epc_crit_q  <= epc_crit_d;
            epc_mchk_q  <= epc_mchk_d;
            arm_q       <= arm_d;
        end
    end

    assign int_valid  = (state_q == S_OFFER);
    assign int_id     = int_id_q;
    assign int_class  = int_class_q;
    assign src_ack    = src_ack_q;
    assign active     = active_q;
    assign epc_base   = epc_base_q;
    assign epc_crit   = epc_crit_q;
    assign epc_mcheck = epc_mchk_q;

endmodule
`default_nettype wire

// File: tb/tb_int_sched_prio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_int_sched_prio
//  Brief    : Directed self-checking bench for int_sched_prio
//             (src 3 edge/base, src 5 critical, src 7 machine-check).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_int_sched_prio;

    localparam int NUM_SRC = 8;
    localparam int ADDR_W  = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic [NUM_SRC-1:0]  src_req;
    logic [NUM_SRC-1:0]  src_ack;
    logic                block_external;
    logic                block;
    logic [ADDR_W-1:0]   pc;
    logic                int_valid;
    logic [2:0]          int_id;
    logic [1:0]          int_class;
    logic                int_ack;
    logic                rest_base;
    logic                rest_crit;
    logic                rest_mcheck;
    logic [ADDR_W-1:0]   epc_base;
    logic [ADDR_W-1:0]   epc_crit;
    logic [ADDR_W-1:0]   epc_mcheck;
    logic [2:0]          active;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        int          cls;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    int_sched_prio #(
        .NUM_SRC     (NUM_SRC),
        .ADDR_W      (ADDR_W),
        .EDGE_MASK   (8'b0000_1000),
        .CRIT_MASK   (8'b0010_0000),
        .MCHECK_MASK (8'b1000_0000),
        .EXT_MASK    (8'b1111_1111)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .src_req        (src_req),
        .src_ack        (src_ack),
        .block_external (block_external),
        .block          (block),
        .pc             (pc),
        .int_valid      (int_valid),
        .int_id         (int_id),
        .int_class      (int_class),
        .int_ack        (int_ack),
        .rest_base      (rest_base),
        .rest_crit      (rest_crit),
        .rest_mcheck    (rest_mcheck),
        .epc_base       (epc_base),
        .epc_crit       (epc_crit),
        .epc_mcheck     (epc_mcheck),
        .active         (active)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pop the oldest expected take and compare it with the DUT response.
    task automatic check_ack();
        exp_t        e;
        logic [31:0] epc_obs;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty: observed no expected entry");
            return;
        end
        e = sb.pop_front();
        chk("src_ack_pulse", src_ack, 64'(1) << e.id);
        epc_obs = (e.cls == 2) ? epc_mcheck : (e.cls == 1) ? epc_crit : epc_base;
        chk("epc_saved", epc_obs, e.epc);
        chk("active_set", active[e.cls], 1);
        chk("valid_after_ack", int_valid, 0);
        tick();
        chk("src_ack_one_cycle", src_ack, 0);
    endtask

    task automatic take(input int id, input int cls, input logic [31:0] pcv);
        exp_t e;
        e.id  = id;
        e.cls = cls;
        e.epc = pcv;
        sb.push_back(e);
        int_ack = 1'b1;
        pc      = pcv;
        tick();
        int_ack = 1'b0;
        pc      = 32'h0;
        check_ack();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b0;
        src_req        = '0;
        block_external = 1'b0;
        block          = 1'b0;
        pc             = '0;
        int_ack        = 1'b0;
        rest_base      = 1'b0;
        rest_crit      = 1'b0;
        rest_mcheck    = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_valid", int_valid, 0);
        chk("rst_id", int_id, 0);
        chk("rst_class", int_class, 0);
        chk("rst_src_ack", src_ack, 0);
        chk("rst_active", active, 0);
        chk("rst_epc_base", epc_base, 0);
        reset = 1'b1;
        tick();
        tick();

        // Edge source 3: one-cycle pulse, offered one cycle later
        src_req[3] = 1'b1;
        tick();
        src_req[3] = 1'b0;
        chk("edge_not_yet", int_valid, 0);
        tick();
        chk("edge_valid", int_valid, 1);
        chk("edge_id", int_id, 3);
        chk("edge_class", int_class, 0);
        take(3, 0, 32'h100);
        chk("edge_active", active, 3'b001);
        chk("edge_no_reoffer", int_valid, 0);
        rest_base = 1'b1;
        tick();
        rest_base = 1'b0;
        chk("rest_base_clears", active, 3'b000);
        tick();
        chk("edge_pending_cleared", int_valid, 0);

        // Base 1 and critical 5 together: critical wins
        src_req[1] = 1'b1;
        src_req[5] = 1'b1;
        tick();
        chk("crit_valid", int_valid, 1);
        chk("crit_id", int_id, 5);
        chk("crit_class", int_class, 1);
        take(5, 1, 32'h200);
        src_req[5] = 1'b0;
        chk("crit_active", active, 3'b010);
        tick();
        chk("base_blocked_by_crit", int_valid, 0);
        rest_crit = 1'b1;
        tick();
        rest_crit = 1'b0;
        chk("rest_crit_clears", active, 3'b000);
        chk("base_not_before_rest", int_valid, 0);
        tick();
        chk("base_after_rest_valid", int_valid, 1);
        chk("base_after_rest_id", int_id, 1);
        chk("epc_base_untouched", epc_base, 32'h100);

        // Withdraw when the offered source drops, then preemption by mcheck
        src_req[1] = 1'b0;
        tick();
        chk("withdraw_valid", int_valid, 0);
        chk("withdraw_no_ack", src_ack, 0);
        src_req[2] = 1'b1;
        tick();
        chk("base2_id", int_id, 2);
        tick();
        chk("base2_hold_valid", int_valid, 1);
        chk("base2_hold_id", int_id, 2);
        src_req[7] = 1'b1;
        tick();
        chk("mchk_valid", int_valid, 1);
        chk("mchk_id", int_id, 7);
        chk("mchk_class", int_class, 2);
        take(7, 2, 32'h300);
        chk("mchk_active", active, 3'b100);
        src_req[7] = 1'b0;
        tick();
        chk("all_blocked_by_mchk", int_valid, 0);
        rest_mcheck = 1'b1;
        tick();
        rest_mcheck = 1'b0;
        tick();
        chk("base2_reoffer_valid", int_valid, 1);
        chk("base2_reoffer_id", int_id, 2);
        chk("base2_reoffer_class", int_class, 0);

        // block withdraws; int_ack in IDLE is ignored
        block = 1'b1;
        tick();
        chk("block_withdraw", int_valid, 0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("idle_ack_no_src_ack", src_ack, 0);
        chk("idle_ack_no_active", active, 0);
        block      = 1'b0;
        src_req[2] = 1'b0;
        tick();
        chk("quiet_after_block", int_valid, 0);

        // block_external masks external source 0
        block_external = 1'b1;
        src_req[0]     = 1'b1;
        tick();
        tick();
        chk("ext_blocked", int_valid, 0);
        block_external = 1'b0;
        tick();
        chk("ext_release_valid", int_valid, 1);
        chk("ext_release_id", int_id, 0);

        // Ack and rest of the same class together: set wins
        rest_base = 1'b1;
        take(0, 0, 32'h400);
        rest_base = 1'b0;
        chk("rest_held_clears", active, 3'b000);
        tick();
        tick();
        chk("reoffer_before_reset", int_valid, 1);

        // Asynchronous reset in the middle of an offer
        reset = 1'b0;
        #1;
        chk("async_rst_valid", int_valid, 0);
        chk("async_rst_src_ack", src_ack, 0);
        chk("async_rst_active", active, 0);
        chk("async_rst_epc_base", epc_base, 0);
        chk("async_rst_epc_crit", epc_crit, 0);
        chk("async_rst_epc_mchk", epc_mcheck, 0);
        tick();
        reset = 1'b1;
        tick();
        chk("post_rst_first_edge", int_valid, 0);
        tick();
        chk("post_rst_second_edge", int_valid, 1);
        chk("post_rst_id", int_id, 0);
        chk("post_rst_no_ack", src_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/int_sched_prio.md
INT_SCHED_PRIO -- requirements
Module: int_sched_prio

Interface
REQ-001 Parameter NUM_SRC, default 8, number of interrupt sources (2..32).
REQ-002 Parameter ADDR_W, default 32, width of pc and saved-pc values.
REQ-003 Parameter EDGE_MASK, default all-0, per source: 1 = edge-triggered, 0 = level.
REQ-004 Parameter CRIT_MASK, default all-0, per source: 1 = critical class.
REQ-005 Parameter MCHECK_MASK, default all-0, per source: 1 = machine-check class (overrides CRIT_MASK).
REQ-006 Parameter EXT_MASK, default all-1, per source: 1 = external, maskable by block_external.
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 src_req  input  NUM_SRC  per-source interrupt request.
REQ-010 src_ack  output  NUM_SRC  one-cycle pulse to the source whose interrupt was taken.
REQ-011 block_external  input  1  suppress offers from EXT_MASK sources.
REQ-012 block  input  1  suppress all offers.
REQ-013 pc  input  ADDR_W  return address sampled when an interrupt is taken.
REQ-014 int_valid  output  1  an interrupt is offered to the core.
REQ-015 int_id  output  $clog2(NUM_SRC)  offered source index.
REQ-016 int_class  output  2  offered class: 0 base, 1 critical, 2 mcheck.
REQ-017 int_ack  input  1  core takes the offered interrupt this cycle.
REQ-018 rest_base, rest_crit, rest_mcheck  input  1 each  return-from-interrupt of that class.
REQ-019 epc_base, epc_crit, epc_mcheck  output  ADDR_W each  saved return pc per class.
REQ-020 active  output  3  in-service bit per class.

Function
REQ-021 Edge source pending bit shall set on a 0->1 transition of src_req (one-cycle-registered previous value) and clear on its src_ack; edge arriving in the ack cycle shall win (stays set).
REQ-022 Level source pending shall equal src_req; the source owns deassertion.
REQ-023 Eligible = pending & ~(block_external ? EXT_MASK : 0), all zero while block = 1.
REQ-024 A class is admissible only if strictly greater than the highest class with active bit set (none active: all admissible).
REQ-025 Selection: highest admissible class first, then lowest source index within class.
REQ-026 FSM states IDLE and OFFER; int_valid = 1 exactly in OFFER.
REQ-027 IDLE -> OFFER one cycle after an eligible admissible source exists; int_id/int_class registered.
REQ-028 In OFFER without int_ack: int_id/int_class hold unless a strictly higher-class source becomes eligible, then update next cycle.
REQ-029 OFFER -> IDLE next cycle if the offered source is no longer eligible, block rises, or class becomes inadmissible (withdraw, no ack pulse).
REQ-030 int_ack while in OFFER: next cycle src_ack[int_id] = 1 for one cycle, active[int_class] set, epc_<class> <= pc sampled in ack cycle, FSM -> IDLE.
REQ-031 int_ack while in IDLE shall be ignored (no state change).
REQ-032 rest_<class> clears active[class] next cycle; rest to a non-active class is a no-op.
REQ-033 Simultaneous int_ack and rest_ of same class: set wins.
REQ-034 Minimum spacing between two acks: 2 cycles (IDLE re-evaluates after ack).
REQ-035 epc registers change only on ack of their class.

Reset
REQ-036 On reset low: FSM IDLE, int_valid 0, int_id 0, int_class 0, src_ack 0, active 0, all pending and previous-request bits 0, all epc 0; takes effect immediately, independent of clk.
REQ-037 Reset asserted mid-OFFER shall drop int_valid without src_ack; first offer after release no earlier than second rising edge.

Verification
REQ-038 Edge src 3 pulses 1 cycle, idle otherwise -> int_valid next+1 cycle, int_id 3, class 0; ack with pc=0x100 -> src_ack[3] pulse, epc_base 0x100, active 001.
REQ-039 Base src 1 and crit src 5 both pending -> offer id 5 class 1; after ack, active 010, src 1 not offered until rest_crit.
REQ-040 Base offer id 2 held without ack, mcheck src 7 asserts -> offer updates to id 7 class 2 next cycle.
REQ-041 block_external=1 with only external src 0 pending -> int_valid stays 0; release -> offer within 1 cycle.
REQ-042 Offer pending, reset pulsed low for 1 cycle -> int_valid 0 immediately, no src_ack, active 000, epc 0.
